// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared definitions for the MEM-stage pipeline blocks.
//   mem_state_t     - FSM state encoding of the data-memory access sequencer
//   mem_size_t      - access size encoding carried on mem_size
//   TIMEOUT_DEFAULT - default maximum number of WAIT cycles before a bus-error abort
//   is_misaligned() - flags accesses that cannot be issued as a single bus beat
package pipeline_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } mem_state_t;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_ILL  = 2'b11
    } mem_size_t;

    localparam int TIMEOUT_DEFAULT = 255;

    // Halves need an even address, words a 4-byte aligned one; the reserved
    // size code is treated as misaligned so it never reaches the bus.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = addr_lo[0];
            SIZE_WORD: bad = (addr_lo != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane steering for the data-memory bus.
// Ports:
//   addr_lo      - in,  2: low address bits selecting the byte/half lane
//   mem_size     - in,  2: access size (byte / half / word)
//   mem_unsigned - in,  1: zero-extend loads when 1, sign-extend when 0
//   store_data   - in, 32: register value to be stored
//   load_word    - in, 32: full word returned by the bus
//   lane_be      - out, 4: byte enables for the store
//   lane_wdata   - out,32: store data replicated across all lanes
//   lane_load    - out,32: selected and extended load data
module mem_lane_align
    import pipeline_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  lane_be,
    output logic [31:0] lane_wdata,
    output logic [31:0] lane_load
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'b00:   byte_sel = load_word[7:0];
            2'b01:   byte_sel = load_word[15:8];
            2'b10:   byte_sel = load_word[23:16];
            default: byte_sel = load_word[31:24];
        endcase
        half_sel = addr_lo[1] ? load_word[31:16] : load_word[15:0];
    end

    always_comb begin
        lane_be    = 4'b1111;
        lane_wdata = store_data;
        lane_load  = load_word;
        case (mem_size)
            SIZE_BYTE: begin
                lane_be    = 4'b0001 << addr_lo;
                lane_wdata = {4{store_data[7:0]}};
                lane_load  = mem_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            SIZE_HALF: begin
                lane_be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{store_data[15:0]}};
                lane_load  = mem_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end
            default: begin
                // Word (the reserved code is never issued): full-width pass-through.
                lane_be    = 4'b1111;
                lane_wdata = store_data;
                lane_load  = load_word;
            end
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: MEM-stage data-memory sequencer. Issues one bus request per
// aligned load/store, stalls the upstream pipeline until the bus acknowledges
// (or a timeout aborts the access), and hands the extended load data plus
// pass-through controls to the MEM/WB register.
// Ports:
//   clk, rst                       - clock, synchronous active-low reset
//   MEM_MemRead / MEM_MemWrite     - load / store in the MEM stage (both => store)
//   MEM_MemtoReg_in, MEM_RegWrite_in, alu_result_in, write_reg_in - EX/MEM fields
//   mem_size, mem_unsigned         - access size and load extension mode
//   write_data_in                  - store data
//   dmem_req/we/addr/wdata/be      - registered bus request, held through WAIT
//   dmem_ack, dmem_rdata           - bus completion and read data
//   read_data_from_mem, alu_result_from_mem, write_reg_from_mem,
//   MEM_MemtoReg, MEM_RegWrite     - fields for the MEM/WB register
//   mem_stall                      - freeze PC, IF/ID, ID/EX and EX/MEM
//   mem_misalign                   - misaligned/illegal access flag (one cycle)
//   mem_bus_err                    - timeout flag, high during the abort DONE cycle
//   state_dbg                      - current FSM state for observation
//
// Handshake: dmem_req is a level request raised on entry to WAIT; dmem_addr,
// dmem_we, dmem_be and dmem_wdata are stable while dmem_req=1. The transfer
// completes on the first clock edge with dmem_req=1 and dmem_ack=1, at which
// point dmem_rdata is captured and dmem_req drops. dmem_ack is ignored
// whenever dmem_req=0.
module mem_access
    import pipeline_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic        MEM_MemtoReg_in,
    input  logic        MEM_RegWrite_in,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] write_data_in,
    input  logic [4:0]  write_reg_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] read_data_from_mem,
    output logic [31:0] alu_result_from_mem,
    output logic [4:0]  write_reg_from_mem,
    output logic        MEM_MemtoReg,
    output logic        MEM_RegWrite,
    output logic        mem_stall,
    output logic        mem_misalign,
    output logic        mem_bus_err,
    output logic [1:0]  state_dbg
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mem_state_t       state, next_state;
    logic [CNT_W-1:0] wait_cnt;
    logic [31:0]      rdata_q;
    logic             pending, is_store, is_load, misaligned;
    logic             start, timeout_hit;
    logic [3:0]       lane_be;
    logic [31:0]      lane_wdata, lane_load;

    assign pending    = MEM_MemRead | MEM_MemWrite;
    assign is_store   = MEM_MemWrite;
    assign is_load    = MEM_MemRead & ~MEM_MemWrite;
    assign misaligned = is_misaligned(mem_size, alu_result_in[1:0]);

    assign alu_result_from_mem = alu_result_in;
    assign write_reg_from_mem  = write_reg_in;
    assign state_dbg           = state;

    // EX/MEM is frozen for the whole access, so the live inputs still describe
    // the same instruction in DONE and can drive load extraction directly.
    mem_lane_align u_lane (
        .addr_lo      (alu_result_in[1:0]),
        .mem_size     (mem_size),
        .mem_unsigned (mem_unsigned),
        .store_data   (write_data_in),
        .load_word    (rdata_q),
        .lane_be      (lane_be),
        .lane_wdata   (lane_wdata),
        .lane_load    (lane_load)
    );

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state         = state;
        start              = 1'b0;
        timeout_hit        = 1'b0;
        mem_stall          = 1'b0;
        mem_misalign       = 1'b0;
        MEM_RegWrite       = MEM_RegWrite_in;
        MEM_MemtoReg       = MEM_MemtoReg_in;
        read_data_from_mem = 32'h0;
        case (state)
            IDLE: begin
                if (pending) begin
                    if (misaligned) begin
                        mem_misalign = 1'b1;
                        MEM_RegWrite = 1'b0;
                    end else begin
                        start      = 1'b1;
                        mem_stall  = 1'b1;
                        next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                mem_stall = 1'b1;
                if (dmem_ack) begin
                    next_state = DONE;
                end else if (wait_cnt >= CNT_LAST) begin
                    // This is the TIMEOUT-th WAIT cycle without an ack.
                    timeout_hit = 1'b1;
                    next_state  = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
                if (mem_bus_err)  MEM_RegWrite       = 1'b0;
                else if (is_load) read_data_from_mem = lane_load;
            end
            default: next_state = IDLE;
        endcase
        // A stalled cycle must reach MEM/WB as a bubble.
        if (mem_stall) begin
            MEM_RegWrite = 1'b0;
            MEM_MemtoReg = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= 32'h0;
            dmem_wdata  <= 32'h0;
            dmem_be     <= 4'h0;
            rdata_q     <= 32'h0;
            wait_cnt    <= '0;
            mem_bus_err <= 1'b0;
        end else begin
            mem_bus_err <= timeout_hit;
            if (start) begin
                dmem_req   <= 1'b1;
                dmem_we    <= is_store;
                dmem_addr  <= {alu_result_in[31:2], 2'b00};
                dmem_be    <= lane_be;
                dmem_wdata <= lane_wdata;
                wait_cnt   <= '0;
            end else if (state == WAIT) begin
                if (dmem_ack) begin
                    dmem_req <= 1'b0;
                    rdata_q  <= dmem_rdata;
                end else begin
                    if (timeout_hit)          dmem_req <= 1'b0;
                    if (wait_cnt != CNT_MAX)  wait_cnt <= wait_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed bench for mem_access. Inputs change 1 ns after the
// rising edge; outputs are checked on the falling edge.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_MemRead, MEM_MemWrite, MEM_MemtoReg_in, MEM_RegWrite_in;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [31:0] alu_result_in, write_data_in;
    logic [4:0]  write_reg_in;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic [31:0] read_data_from_mem, alu_result_from_mem;
    logic [4:0]  write_reg_from_mem;
    logic        MEM_MemtoReg, MEM_RegWrite, mem_stall, mem_misalign, mem_bus_err;
    logic [1:0]  state_dbg;

    int tests  = 0;
    int failed = 0;
    int stall_cycles;
    int wait_cycles;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_WAIT = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    mem_access dut (
        .clk                 (clk),
        .rst                 (rst),
        .MEM_MemRead         (MEM_MemRead),
        .MEM_MemWrite        (MEM_MemWrite),
        .MEM_MemtoReg_in     (MEM_MemtoReg_in),
        .MEM_RegWrite_in     (MEM_RegWrite_in),
        .mem_size            (mem_size),
        .mem_unsigned        (mem_unsigned),
        .alu_result_in       (alu_result_in),
        .write_data_in       (write_data_in),
        .write_reg_in        (write_reg_in),
        .dmem_req            (dmem_req),
        .dmem_we             (dmem_we),
        .dmem_addr           (dmem_addr),
        .dmem_wdata          (dmem_wdata),
        .dmem_be             (dmem_be),
        .dmem_ack            (dmem_ack),
        .dmem_rdata          (dmem_rdata),
        .read_data_from_mem  (read_data_from_mem),
        .alu_result_from_mem (alu_result_from_mem),
        .write_reg_from_mem  (write_reg_from_mem),
        .MEM_MemtoReg        (MEM_MemtoReg),
        .MEM_RegWrite        (MEM_RegWrite),
        .mem_stall           (mem_stall),
        .mem_misalign        (mem_misalign),
        .mem_bus_err         (mem_bus_err),
        .state_dbg           (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        MEM_MemRead     = 1'b0;
        MEM_MemWrite    = 1'b0;
        MEM_MemtoReg_in = 1'b0;
        MEM_RegWrite_in = 1'b0;
        mem_size        = 2'b00;
        mem_unsigned    = 1'b0;
        alu_result_in   = 32'h0;
        write_data_in   = 32'h0;
        write_reg_in    = 5'd0;
    endtask

    task automatic set_load(input logic [31:0] addr, input logic [1:0] size, input logic uns);
        MEM_MemRead     = 1'b1;
        MEM_MemWrite    = 1'b0;
        MEM_MemtoReg_in = 1'b1;
        MEM_RegWrite_in = 1'b1;
        mem_size        = size;
        mem_unsigned    = uns;
        alu_result_in   = addr;
        write_reg_in    = 5'd7;
    endtask

    // Caller has just applied a load; walks IDLE -> WAIT (ack at once) -> DONE
    // and returns at the falling edge of the DONE cycle.
    task automatic zero_wait_load(input logic [31:0] rdata);
        tick();
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        @(negedge clk);
    endtask

    initial begin
        rst        = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        clear_inputs();

        // ---- reset state ----
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        check("rst_req", 32'(dmem_req), 32'h0);
        check("rst_we", 32'(dmem_we), 32'h0);
        check("rst_addr", dmem_addr, 32'h0);
        check("rst_wdata", dmem_wdata, 32'h0);
        check("rst_be", 32'(dmem_be), 32'h0);
        check("rst_bus_err", 32'(mem_bus_err), 32'h0);
        check("rst_stall", 32'(mem_stall), 32'h0);
        tick();
        rst = 1'b1;

        // ---- idle pass-through of an ALU op ----
        MEM_RegWrite_in = 1'b1;
        MEM_MemtoReg_in = 1'b0;
        alu_result_in   = 32'h0000_0042;
        write_reg_in    = 5'd9;
        @(negedge clk);
        check("alu_pass", alu_result_from_mem, 32'h0000_0042);
        check("wreg_pass", 32'(write_reg_from_mem), 32'd9);
        check("regwrite_pass", 32'(MEM_RegWrite), 32'h1);
        check("alu_stall", 32'(mem_stall), 32'h0);
        check("alu_rdata", read_data_from_mem, 32'h0);
        tick();

        // ---- LW 0x100, zero-wait ack ----
        set_load(32'h0000_0100, 2'b10, 1'b0);
        stall_cycles = 0;
        @(negedge clk);
        if (mem_stall) stall_cycles++;
        check("lw_idle_regwrite", 32'(MEM_RegWrite), 32'h0);
        check("lw_idle_memtoreg", 32'(MEM_MemtoReg), 32'h0);
        tick();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        if (mem_stall) stall_cycles++;
        check("lw_wait_state", 32'(state_dbg), 32'(ST_WAIT));
        check("lw_req", 32'(dmem_req), 32'h1);
        check("lw_addr", dmem_addr, 32'h0000_0100);
        check("lw_we", 32'(dmem_we), 32'h0);
        check("lw_be", 32'(dmem_be), 32'hF);
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        @(negedge clk);
        if (mem_stall) stall_cycles++;
        check("lw_stall_cycles", 32'(stall_cycles), 32'd2);
        check("lw_done_state", 32'(state_dbg), 32'(ST_DONE));
        check("lw_data", read_data_from_mem, 32'hDEAD_BEEF);
        check("lw_regwrite", 32'(MEM_RegWrite), 32'h1);
        check("lw_memtoreg", 32'(MEM_MemtoReg), 32'h1);
        check("lw_req_clr", 32'(dmem_req), 32'h0);
        tick();
        clear_inputs();
        @(negedge clk);
        check("lw_back_idle", 32'(state_dbg), 32'(ST_IDLE));
        tick();

        // ---- LB 0x103 signed, then unsigned ----
        set_load(32'h0000_0103, 2'b00, 1'b0);
        zero_wait_load(32'h80FF_FFFF);
        check("lb_signed", read_data_from_mem, 32'hFFFF_FF80);
        tick();
        clear_inputs();
        tick();
        set_load(32'h0000_0103, 2'b00, 1'b1);
        zero_wait_load(32'h80FF_FFFF);
        check("lbu_unsigned", read_data_from_mem, 32'h0000_0080);
        tick();
        clear_inputs();
        tick();

        // ---- LH 0x102 signed: upper half ----
        set_load(32'h0000_0102, 2'b01, 1'b0);
        zero_wait_load(32'h9ABC_1234);
        check("lh_signed", read_data_from_mem, 32'hFFFF_9ABC);
        tick();
        clear_inputs();
        tick();

        // ---- SH 0x102, ack after 3 WAIT cycles ----
        MEM_MemWrite  = 1'b1;
        mem_size      = 2'b01;
        alu_result_in = 32'h0000_0102;
        write_data_in = 32'h1234_ABCD;
        @(negedge clk);
        check("sh_idle_stall", 32'(mem_stall), 32'h1);
        tick();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("sh_hold_req", 32'(dmem_req), 32'h1);
            check("sh_hold_we", 32'(dmem_we), 32'h1);
            check("sh_hold_be", 32'(dmem_be), 32'hC);
            check("sh_hold_wdata", dmem_wdata, 32'hABCD_ABCD);
            check("sh_hold_addr", dmem_addr, 32'h0000_0100);
            check("sh_hold_stall", 32'(mem_stall), 32'h1);
            tick();
        end
        dmem_ack = 1'b1;
        @(negedge clk);
        check("sh_ack_be", 32'(dmem_be), 32'hC);
        tick();
        dmem_ack = 1'b0;
        @(negedge clk);
        check("sh_done_state", 32'(state_dbg), 32'(ST_DONE));
        check("sh_done_stall", 32'(mem_stall), 32'h0);
        check("sh_done_req", 32'(dmem_req), 32'h0);
        check("sh_done_rdata", read_data_from_mem, 32'h0);
        tick();
        clear_inputs();
        tick();

        // ---- SB 0x101: lane 1 ----
        MEM_MemWrite  = 1'b1;
        mem_size      = 2'b00;
        alu_result_in = 32'h0000_0101;
        write_data_in = 32'hFFFF_FF5A;
        tick();
        @(negedge clk);
        check("sb_be", 32'(dmem_be), 32'h2);
        check("sb_wdata", dmem_wdata, 32'h5A5A_5A5A);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        tick();
        clear_inputs();
        tick();

        // ---- LW 0x101: misaligned ----
        set_load(32'h0000_0101, 2'b10, 1'b0);
        @(negedge clk);
        check("mis_flag", 32'(mem_misalign), 32'h1);
        check("mis_stall", 32'(mem_stall), 32'h0);
        check("mis_regwrite", 32'(MEM_RegWrite), 32'h0);
        tick();
        clear_inputs();
        @(negedge clk);
        check("mis_no_req", 32'(dmem_req), 32'h0);
        check("mis_state", 32'(state_dbg), 32'(ST_IDLE));
        check("mis_flag_clr", 32'(mem_misalign), 32'h0);
        tick();

        // ---- illegal size ----
        set_load(32'h0000_0200, 2'b11, 1'b0);
        @(negedge clk);
        check("ill_flag", 32'(mem_misalign), 32'h1);
        tick();
        clear_inputs();
        @(negedge clk);
        check("ill_no_req", 32'(dmem_req), 32'h0);
        tick();

        // ---- ack withheld: timeout after 255 WAIT cycles ----
        set_load(32'h0000_0200, 2'b10, 1'b0);
        tick();
        wait_cycles = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (state_dbg != ST_WAIT) break;
            wait_cycles++;
            tick();
        end
        check("to_wait_cycles", 32'(wait_cycles), 32'd255);
        check("to_state_done", 32'(state_dbg), 32'(ST_DONE));
        check("to_bus_err", 32'(mem_bus_err), 32'h1);
        check("to_req_clr", 32'(dmem_req), 32'h0);
        check("to_regwrite", 32'(MEM_RegWrite), 32'h0);
        tick();
        clear_inputs();
        @(negedge clk);
        check("to_state_idle", 32'(state_dbg), 32'(ST_IDLE));
        check("to_bus_err_clr", 32'(mem_bus_err), 32'h0);
        tick();

        // ---- reset during WAIT, late ack ----
        set_load(32'h0000_0300, 2'b10, 1'b0);
        tick();
        @(negedge clk);
        check("rw_req", 32'(dmem_req), 32'h1);
        tick();
        rst = 1'b0;
        clear_inputs();
        tick();
        rst        = 1'b1;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1111_2222;
        @(negedge clk);
        check("rw_req_clr", 32'(dmem_req), 32'h0);
        check("rw_state", 32'(state_dbg), 32'(ST_IDLE));
        check("rw_addr_clr", dmem_addr, 32'h0);
        check("rw_stall", 32'(mem_stall), 32'h0);
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        @(negedge clk);
        check("rw_state_after", 32'(state_dbg), 32'(ST_IDLE));
        check("rw_regwrite", 32'(MEM_RegWrite), 32'h0);
        check("rw_rdata", read_data_from_mem, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
